// File: rtl/zbt_proc_writer.sv
// ---------------------------------------------------------------------------
// zbt_proc_writer
//
// Purpose:
//   Sits downstream of the edge-processing stage. Each new processed pixel
//   pair (two 18-bit pixels packed into 36 bits) is captured together with
//   its ZBT bank-1 word address and queued in a small FIFO. The FIFO drains
//   into bank 1 only in cycles where the display reader does not own the
//   bus, so the edge pipeline's output timing is decoupled from the bank-1
//   read/write arbitration.
//
// Ports:
//   clk             in   1      system clock, all logic on posedge
//   reset           in   1      asynchronous, active-high reset
//   two_proc_pixs   in   36     processed pixel pair
//   proc_pix_addr   in   19     bank-1 word address of two_proc_pixs
//   rd_slot         in   1      1 = display reader owns bank 1, no write issues
//   mem_we          out  1      one-cycle write strobe to bank 1
//   mem_addr        out  19     write address, valid while mem_we=1
//   mem_write_data  out  36     write data, valid DATA_LAT cycles after mem_we
//   fifo_level      out  LVL_W  FIFO occupancy, 0..FIFO_DEPTH
//   overflow        out  1      sticky, set when a capture is dropped on full
//
// Build option:
//   ADDR_CLAMP_EN   when defined, new pairs whose address is >= ADDR_LIMIT
//                   are discarded instead of being queued.
// ---------------------------------------------------------------------------
module zbt_proc_writer #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          PTR_W      = 3,
  parameter int          LVL_W      = 4,
  parameter int          DATA_LAT   = 2,
  parameter logic [18:0] ADDR_LIMIT = 19'd307200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [35:0]      two_proc_pixs,
  input  logic [18:0]      proc_pix_addr,
  input  logic             rd_slot,
  output logic             mem_we,
  output logic [18:0]      mem_addr,
  output logic [35:0]      mem_write_data,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam int ENTRY_W = 19 + 36;

  // With the clamp disabled the limit gets bit 19 set, which is larger than
  // any 19-bit address, so every address counts as inside the frame.
  localparam logic [19:0] CLAMP_LIMIT =
`ifdef ADDR_CLAMP_EN
    {1'b0, ADDR_LIMIT};
`else
    {1'b1, ADDR_LIMIT};
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_reg;
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [LVL_W-1:0]    level_reg;
  logic [LVL_W-1:0]    level_next;
  logic                first_flag_reg;
  logic [18:0]         last_addr_reg;
  logic                overflow_reg;
  logic                mem_we_reg;
  logic [18:0]         mem_addr_reg;
  logic [35:0]         mem_write_data_reg;

  // FIFO storage: {addr, data} per entry; no reset, only pointers are cleared.
  logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]  head_entry;

  // -------------------------------------------------------------------------
  // Capture / push / pop decisions
  // -------------------------------------------------------------------------
  logic is_new;
  logic addr_in_frame;
  logic push_req;
  logic push_ok;
  logic drop;
  logic pop;
  logic fifo_full;
  logic fifo_empty;

  assign fifo_empty    = (level_reg == '0);
  assign fifo_full     = (level_reg == LVL_W'(FIFO_DEPTH));
  assign is_new        = first_flag_reg || (proc_pix_addr != last_addr_reg);
  assign addr_in_frame = ({1'b0, proc_pix_addr} < CLAMP_LIMIT);
  assign push_req      = is_new && addr_in_frame;

  // A pop frees a slot in the same edge, so a push on full is still accepted.
  assign pop     = (state_reg != S_IDLE) && !fifo_empty && !rd_slot;
  assign push_ok = push_req && (!fifo_full || pop);
  assign drop    = push_req && fifo_full && !pop;

  assign level_next = level_reg + LVL_W'(push_ok) - LVL_W'(pop);

  assign head_entry = fifo_mem[rd_ptr_reg];

  // -------------------------------------------------------------------------
  // FIFO write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= {proc_pix_addr, two_proc_pixs};
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM, FIFO pointers and registered write-command outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      first_flag_reg <= 1'b1;
      last_addr_reg  <= '0;
      overflow_reg   <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
    end else begin
      // last_addr tracks every new address, even dropped or clamped ones,
      // so a held address is never captured twice.
      if (is_new) begin
        last_addr_reg  <= proc_pix_addr;
        first_flag_reg <= 1'b0;
      end

      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end

      if (drop) begin
        overflow_reg <= 1'b1;
      end

      // mem_addr holds its last value between writes.
      mem_we_reg <= pop;
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
        mem_addr_reg <= head_entry[ENTRY_W-1:36];
      end

      level_reg <= level_next;

      case (state_reg)
        S_IDLE: begin
          if (push_ok) begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT, S_ISSUE: begin
          if (level_next == '0) begin
            state_reg <= S_IDLE;
          end else if (pop) begin
            state_reg <= S_ISSUE;
          end else begin
            state_reg <= S_WAIT;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Write-data delay line. Stage 0 is loaded on the same edge that raises
  // mem_we; after DATA_LAT stages the output register updates, so data lands
  // exactly DATA_LAT cycles after its strobe. Valid bits let the output hold
  // the last written word while idle.
  // -------------------------------------------------------------------------
  logic [35:0] pipe_data [DATA_LAT+1];
  logic        pipe_vld  [DATA_LAT+1];

  assign pipe_data[0] = head_entry[35:0];
  assign pipe_vld[0]  = pop;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_LAT; gi++) begin : g_pipe
      logic [35:0] data_reg;
      logic        vld_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_reg <= '0;
          vld_reg  <= 1'b0;
        end else begin
          vld_reg <= pipe_vld[gi];
          if (pipe_vld[gi]) begin
            data_reg <= pipe_data[gi];
          end
        end
      end

      assign pipe_data[gi+1] = data_reg;
      assign pipe_vld[gi+1]  = vld_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_write_data_reg <= '0;
    end else if (pipe_vld[DATA_LAT]) begin
      mem_write_data_reg <= pipe_data[DATA_LAT];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_we         = mem_we_reg;
  assign mem_addr       = mem_addr_reg;
  assign mem_write_data = mem_write_data_reg;
  assign fifo_level     = level_reg;
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_zbt_proc_writer.sv
// ---------------------------------------------------------------------------
// tb_zbt_proc_writer
//
// Directed bench for zbt_proc_writer. Inputs change on the falling edge,
// outputs are logged on the falling edge into per-cycle history arrays,
// and each directed step checks live outputs or the history against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_zbt_proc_writer;

  localparam int HIST = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [35:0] two_proc_pixs = '0;
  logic [18:0] proc_pix_addr = '0;
  logic        rd_slot = 1'b0;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [35:0] mem_write_data;
  logic [3:0]  fifo_level;
  logic        overflow;

  zbt_proc_writer dut (
    .clk            (clk),
    .reset          (reset),
    .two_proc_pixs  (two_proc_pixs),
    .proc_pix_addr  (proc_pix_addr),
    .rd_slot        (rd_slot),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        we_h   [HIST];
  logic [18:0] addr_h [HIST];
  logic [35:0] data_h [HIST];

  always @(negedge clk) begin
    if (cyc < HIST) begin
      we_h[cyc]   <= mem_we;
      addr_h[cyc] <= mem_addr;
      data_h[cyc] <= mem_write_data;
    end
    if (mem_we === 1'b1)
      $display("write cycle=%0d addr=%0d level=%0d", cyc, mem_addr, fifo_level);
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic int count_we(input int a, input int b);
    int c;
    c = 0;
    for (int k = a; k <= b; k++)
      if (we_h[k] === 1'b1) c++;
    return c;
  endfunction

`ifdef ADDR_CLAMP_EN
  localparam int EXP_CLAMP_WRITES = 1;
`else
  localparam int EXP_CLAMP_WRITES = 2;
`endif

  initial begin
    int b;

    // ---------------- Reset state ----------------
    reset = 1'b1; rd_slot = 1'b0;
    proc_pix_addr = 19'd100; two_proc_pixs = 36'hA5A5A5A5A;
    tick(2);
    chk("rst_we",    64'(mem_we), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    chk("rst_addr",  64'(mem_addr), 64'd0);
    chk("rst_data",  64'(mem_write_data), 64'd0);

    // ---------------- 1: single write latency ----------------
    reset = 1'b0; b = cyc;
    tick(1);
    chk("t1_level_after_push", 64'(fifo_level), 64'd1);
    chk("t1_we_not_yet", 64'(mem_we), 64'd0);
    tick(1);
    chk("t1_we", 64'(mem_we), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'd100);
    tick(9);
    chk("t1_one_write", 64'(count_we(b + 1, b + 10)), 64'd1);
    chk("t1_data_early", 64'(data_h[b + 3]), 64'd0);
    chk("t1_data", 64'(data_h[b + 4]), 64'hA5A5A5A5A);
    chk("t1_data_hold", 64'(data_h[b + 9]), 64'hA5A5A5A5A);

    // ---------------- 2: fill to full, overflow, in-order drain ----------------
    rd_slot = 1'b1;
    for (int i = 0; i < 8; i++) begin
      proc_pix_addr = 19'(i);
      two_proc_pixs = 36'h100000000 | 36'(i);
      tick(1);
    end
    chk("t2_level_full", 64'(fifo_level), 64'd8);
    chk("t2_ovf_clear", 64'(overflow), 64'd0);
    proc_pix_addr = 19'd8; two_proc_pixs = 36'h100000008;
    tick(1);
    chk("t2_ovf_set", 64'(overflow), 64'd1);
    chk("t2_level_still_full", 64'(fifo_level), 64'd8);
    rd_slot = 1'b0; b = cyc;
    tick(13);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_we_%0d", i), 64'(we_h[b + 1 + i]), 64'd1);
      chk($sformatf("t2_addr_%0d", i), 64'(addr_h[b + 1 + i]), 64'(i));
    end
    chk("t2_count", 64'(count_we(b + 1, b + 12)), 64'd8);
    chk("t2_data_first", 64'(data_h[b + 3]), 64'h100000000);
    chk("t2_data_last", 64'(data_h[b + 10]), 64'h100000007);
    chk("t2_level_empty", 64'(fifo_level), 64'd0);
    chk("t2_ovf_sticky", 64'(overflow), 64'd1);

    // ---------------- 3: push on full with simultaneous pop ----------------
    reset = 1'b1; tick(1); reset = 1'b0;
    rd_slot = 1'b1;
    for (int i = 0; i < 8; i++) begin
      proc_pix_addr = 19'(10 + i);
      two_proc_pixs = 36'h200000000 | 36'(10 + i);
      tick(1);
    end
    chk("t3_level_full", 64'(fifo_level), 64'd8);
    rd_slot = 1'b0; proc_pix_addr = 19'd50; two_proc_pixs = 36'h200000032; b = cyc;
    tick(1);
    chk("t3_level_stays", 64'(fifo_level), 64'd8);
    chk("t3_ovf_stays", 64'(overflow), 64'd0);
    tick(13);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3_addr_%0d", i), 64'(addr_h[b + 1 + i]), 64'(10 + i));
    chk("t3_last_we", 64'(we_h[b + 9]), 64'd1);
    chk("t3_last_addr", 64'(addr_h[b + 9]), 64'd50);
    chk("t3_count", 64'(count_we(b + 1, b + 13)), 64'd9);
    chk("t3_last_data", 64'(data_h[b + 11]), 64'h200000032);

    // ---------------- 4: rd_slot toggling every cycle ----------------
    b = cyc;
    for (int k = 0; k < 10; k++) begin
      rd_slot = (k % 2 == 0);
      if (k < 4) proc_pix_addr = 19'(200 + k);
      tick(1);
    end
    rd_slot = 1'b0;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_we_%0d", i), 64'(we_h[b + 2 + 2 * i]), 64'd1);
      chk($sformatf("t4_addr_%0d", i), 64'(addr_h[b + 2 + 2 * i]), 64'(200 + i));
    end
    chk("t4_no_we_in_rd_slot", 64'(we_h[b + 3]), 64'd0);
    chk("t4_count", 64'(count_we(b + 1, b + 12)), 64'd4);

    // ---------------- 5: async reset mid-drain ----------------
    rd_slot = 1'b1;
    for (int i = 0; i < 8; i++) begin
      proc_pix_addr = 19'(300 + i);
      tick(1);
    end
    rd_slot = 1'b0;
    tick(3);
    chk("t5_level_5", 64'(fifo_level), 64'd5);
    chk("t5_we_draining", 64'(mem_we), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_we", 64'(mem_we), 64'd0);
    chk("t5_async_level", 64'(fifo_level), 64'd0);
    tick(1);
    reset = 1'b0; b = cyc;
    tick(6);
    chk("t5_recapture_we", 64'(we_h[b + 2]), 64'd1);
    chk("t5_recapture_addr", 64'(addr_h[b + 2]), 64'd307);
    chk("t5_recapture_count", 64'(count_we(b + 1, b + 5)), 64'd1);

    // ---------------- 6: frame-limit boundary ----------------
    b = cyc;
    proc_pix_addr = 19'd307199; tick(1);
    proc_pix_addr = 19'd307200; tick(1);
    tick(6);
    chk("t6_first_addr", 64'(addr_h[b + 2]), 64'd307199);
    chk("t6_count", 64'(count_we(b + 1, b + 7)), 64'(EXP_CLAMP_WRITES));
    if (EXP_CLAMP_WRITES == 2)
      chk("t6_second_addr", 64'(addr_h[b + 3]), 64'd307200);
    else
      chk("t6_second_level", 64'(fifo_level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the end of the directed sequence");
    $fatal(1, "watchdog");
  end

endmodule
